// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 Booth multiplier, one partial product per clock.
// Signed or unsigned operands; both are widened by two bits so one datapath serves both modes.
module booth_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);
   localparam int EW = WIDTH + 2;
   localparam int HW = WIDTH + 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [EW-1:0]      a_q, a_d, lo_q, lo_d;
   logic [HW-1:0]      hi_q, hi_d;
   logic               prev_q, prev_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [2:0]         win;
   logic               neg, two, zero;
   logic [HW-1:0]      a_ext, mag, pp, sum;
   logic signed [HW+EW-1:0] shifted;
   // {hi_q, lo_q} is the accumulator; lo_q starts as the multiplier and is shifted out as digits are consumed
   assign win     = {lo_q[1:0], prev_q};
   assign neg     = win[2];
   assign two     = (win == 3'b011) || (win == 3'b100);
   assign zero    = (win == 3'b000) || (win == 3'b111);
   assign a_ext   = {{2{a_q[EW-1]}}, a_q};
   assign mag     = two ? (a_ext << 1) : a_ext;
   assign pp      = zero ? '0 : (neg ? -mag : mag);
   assign sum     = hi_q + pp;
   assign shifted = $signed({sum, lo_q}) >>> 2;
   assign busy    = state_q == RUN;
   assign done    = state_q == DONE;
   assign product = product_q;
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = start ? RUN : IDLE;
            if (start) begin
               a_d    = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
               lo_d   = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
               hi_d   = '0;
               prev_d = 1'b0;
               cnt_d  = CW'(N);
            end
         end
         RUN: begin
            hi_d   = shifted[HW+EW-1:EW];
            lo_d   = shifted[EW-1:0];
            prev_d = lo_q[1];
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               product_d = shifted[2*WIDTH-1:0];
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         prev_q    <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: table vectors, corner sequences and random scoreboard checks
// on a 32-bit and an 8-bit instance sharing clock and reset.
module tb_booth_seq_multiplier;
   logic        clk = 1'b0, reset = 1'b1;
   logic        s32 = 1'b0, sm32 = 1'b0, s8 = 1'b0, sm8 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy32, done32, busy8, done8;
   logic [63:0] p32;
   logic [15:0] p8;
   logic [63:0] q32[$];
   logic [15:0] q8[$];
   int          n_cmp = 0, n_err = 0;
   typedef struct {
      logic        sm;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl[9];

   booth_seq_multiplier #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(s32), .signed_mode(sm32),
      .multiplicand(a32), .multiplier(b32), .busy(busy32), .done(done32), .product(p32));
   booth_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(s8), .signed_mode(sm8),
      .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(p8));

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref32(input logic sm, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = sm ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sm ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] ea, eb;
      ea = sm ? {{8{a[7]}}, a} : {8'b0, a};
      eb = sm ? {{8{b[7]}}, b} : {8'b0, b};
      return ea * eb;
   endfunction

   always @(negedge clk) begin
      if (done32) begin
         if (q32.size() == 0) chk("dut32 unexpected done product", p32, 64'hx);
         else chk("dut32 product", p32, q32.pop_front());
      end
      if (done8) begin
         if (q8.size() == 0) chk("dut8 unexpected done product", {48'b0, p8}, 64'hx);
         else chk("dut8 product", {48'b0, p8}, {48'b0, q8.pop_front()});
      end
   end

   task automatic wait32(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done32) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      int lat;
      @(negedge clk);
      s32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
      q32.push_back(exp);
      @(posedge clk);
      #1 s32 = 1'b0;
      chk("dut32 busy after accept", {63'b0, busy32}, 64'd1);
      wait32(lat);
      chk("dut32 done latency", 64'(lat), 64'd17);
      @(posedge clk);
      #1;
      chk("dut32 done single pulse", {63'b0, done32}, 64'd0);
      chk("dut32 product hold", p32, exp);
   endtask

   task automatic wait8(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done8) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int lat, nd, d1, d2;
      logic ok;
      logic [7:0] ra, rb;
      tbl[0] = '{1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB};
      tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
      tbl[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      tbl[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      tbl[5] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
      tbl[6] = '{1'b0, 32'h0, 32'h1234, 64'h0};
      tbl[7] = '{1'b0, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780};
      tbl[8] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0002};
      #3;
      chk("reset busy", {63'b0, busy32}, 64'd0);
      chk("reset done", {63'b0, done32}, 64'd0);
      chk("reset product", p32, 64'd0);
      chk("reset product8", {48'b0, p8}, 64'd0);
      s32 = 1'b1; sm32 = 1'b1; a32 = 32'hFFFF_FFF9; b32 = 32'd3;
      repeat (2) @(posedge clk);
      #1;
      chk("start ignored in reset", {63'b0, busy32}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      q32.push_back(64'hFFFF_FFFF_FFFF_FFEB);
      @(posedge clk);
      #1 s32 = 1'b0;
      chk("busy after reset release", {63'b0, busy32}, 64'd1);
      wait32(lat);
      chk("first latency", 64'(lat), 64'd17);
      for (int i = 0; i < 9; i++) run32(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].exp);
      // start pulsed again mid-run with new operands must be ignored
      @(negedge clk);
      s32 = 1'b1; sm32 = 1'b1; a32 = 32'hFFFF_FFF9; b32 = 32'd3;
      q32.push_back(64'hFFFF_FFFF_FFFF_FFEB);
      @(posedge clk);
      #1 s32 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      s32 = 1'b1; sm32 = 1'b0; a32 = 32'd123; b32 = 32'd456;
      @(posedge clk);
      #1 s32 = 1'b0;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (done32) nd++;
      end
      chk("ignored start done count", 64'(nd), 64'd1);
      // reset mid-run aborts without a done pulse
      @(negedge clk);
      s32 = 1'b1; sm32 = 1'b0; a32 = 32'd5; b32 = 32'd6;
      @(posedge clk);
      #1 s32 = 1'b0;
      repeat (8) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort busy", {63'b0, busy32}, 64'd0);
      chk("abort done", {63'b0, done32}, 64'd0);
      chk("abort product", p32, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (done32) nd++;
      end
      chk("abort done count", 64'(nd), 64'd0);
      run32(1'b0, 32'd5, 32'd6, 64'd30);
      // 8-bit back-to-back with start held through DONE
      @(negedge clk);
      s8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
      q8.push_back(16'd600);
      @(posedge clk);
      #1;
      d1 = -1; d2 = -1; nd = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) begin
            sm8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
            q8.push_back(16'hC080);
         end
         if (i == 6) s8 = 1'b0;
         if (done8) begin
            nd++;
            if (d1 < 0) d1 = i;
            else d2 = i;
         end
      end
      chk("b2b done count", 64'(nd), 64'd2);
      chk("b2b first done edge", 64'(d1), 64'd5);
      chk("b2b second done edge", 64'(d2), 64'd11);
      chk("b2b product hold", {48'b0, p8}, 64'h0000_0000_0000_C080);
      // random 8-bit back-to-back, one mode at a time
      for (int m = 0; m < 2; m++) begin
         @(negedge clk);
         ra = 8'($urandom); rb = 8'($urandom);
         s8 = 1'b1; sm8 = m[0]; a8 = ra; b8 = rb;
         q8.push_back(ref8(m[0], ra, rb));
         for (int k = 1; k < 3000; k++) begin
            wait8(ok);
            if (!ok) begin
               chk("dut8 random done timeout", 64'd0, 64'd1);
               break;
            end
            ra = 8'($urandom); rb = 8'($urandom);
            a8 = ra; b8 = rb;
            q8.push_back(ref8(m[0], ra, rb));
         end
         wait8(ok);
         s8 = 1'b0;
         chk("dut8 random last done", {63'b0, ok}, 64'd1);
         repeat (2) @(posedge clk);
      end
      for (int k = 0; k < 150; k++) begin
         logic [31:0] ra32, rb32;
         logic        rs;
         ra32 = $urandom; rb32 = $urandom; rs = 1'($urandom);
         if (k % 10 == 0) ra32 = 32'h8000_0000;
         run32(rs, ra32, rb32, ref32(rs, ra32, rb32));
      end
      repeat (3) @(posedge clk);
      #1;
      chk("dut32 scoreboard drained", 64'(q32.size()), 64'd0);
      chk("dut8 scoreboard drained", 64'(q8.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
